// File: rtl/sr_gated_latch.sv
// sr_gated_latch: clocked gated SR latch bank, one set/reset cell per bit.
// Ports: clk, rst_n (async, active low), en (shared gate), s/r (per-cell
// requests), q/qn (complementary outputs), illegal (per-cell forbidden flag).
module sr_gated_latch #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] illegal
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] forb;

  logic [WIDTH-1:0] set_v;
  logic [WIDTH-1:0] clr_v;
  logic [WIDTH-1:0] bad_v;
  logic [WIDTH-1:0] upd_v;

  // Cells with s=r=0 are excluded from upd_v and therefore hold.
  assign set_v = s & ~r;
  assign clr_v = r & ~s;
  assign bad_v = s & r;
  assign upd_v = set_v | clr_v | bad_v;

  // s/r are only looked at under en, so X/Z on a closed gate is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      forb  <= '0;
    end else if (en) begin
      state <= (state & ~upd_v) | set_v;
      forb  <= (forb  & ~upd_v) | bad_v;
    end
  end

  // Outputs are registered state only; the forbidden case pulls both low.
  assign q       = state & ~forb;
  assign qn      = ~state & ~forb;
  assign illegal = forb;

endmodule

// File: tb/tb_sr_gated_latch.sv
// tb_sr_gated_latch: directed vectors plus randomized run checked
// against a per-cell behavioural model (values: 0=reset, 1=set, 2=forbidden).
module tb_sr_gated_latch;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       s1, r1;
  logic       q1, qn1, il1;
  logic [3:0] s4, r4;
  logic [3:0] q4, qn4, il4;

  int n_run;
  int n_fail;

  int m1;
  int m4 [4];

  typedef struct {
    logic s;
    logic r;
    logic q;
    logic qn;
    logic il;
  } vec_t;

  vec_t tbl [8];

  sr_gated_latch #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .s       (s1),
    .r       (r1),
    .q       (q1),
    .qn      (qn1),
    .illegal (il1)
  );

  sr_gated_latch #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .s       (s4),
    .r       (r4),
    .q       (q4),
    .qn      (qn4),
    .illegal (il4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(string nm, logic eq, logic eqn, logic eil);
    chk({nm, ".q"},  {3'b0, q1},  {3'b0, eq});
    chk({nm, ".qn"}, {3'b0, qn1}, {3'b0, eqn});
    chk({nm, ".il"}, {3'b0, il1}, {3'b0, eil});
  endtask

  function automatic int next_cell(int cur, logic e, logic ss, logic rr);
    if (e !== 1'b1) return cur;
    if (ss === 1'b1 && rr === 1'b1) return 2;
    if (ss === 1'b1) return 1;
    if (rr === 1'b1) return 0;
    return cur;
  endfunction

  task automatic model_check(string nm);
    logic [3:0] eq, eqn, eil;
    for (int i = 0; i < 4; i++) begin
      eq[i]  = (m4[i] == 1);
      eqn[i] = (m4[i] == 0);
      eil[i] = (m4[i] == 2);
    end
    chk({nm, ".q4"},  q4,  eq);
    chk({nm, ".qn4"}, qn4, eqn);
    chk({nm, ".il4"}, il4, eil);
    chk({nm, ".inv4"}, qn4 & ~il4, ~q4 & ~il4);
    chk1(nm, m1 == 1, m1 == 0, m1 == 2);
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    m1 = 0;
    for (int i = 0; i < 4; i++) m4[i] = 0;
    #1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1;
    en    = 1'b0;
    s1 = 1'b0; r1 = 1'b0;
    s4 = '0;   r4 = '0;
    tick();
    tick();

    // async reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk1("rst", 1'b0, 1'b1, 1'b0);
    chk("rst.q4", q4, 4'b0000);
    chk("rst.qn4", qn4, 4'b1111);
    chk("rst.il4", il4, 4'b0000);
    #1 rst_n = 1'b1;

    // gate closed with set request
    s1 = 1'b1; r1 = 1'b0; en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("hold_en0", 1'b0, 1'b1, 1'b0);
    end

    // s/r sequence with gate open
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s1 = tbl[k].s;
      r1 = tbl[k].r;
      tick();
      chk1($sformatf("seq%0d", k), tbl[k].q, tbl[k].qn, tbl[k].il);
    end

    // gate closed after set
    s1 = 1'b1; r1 = 1'b0; en = 1'b1;
    tick();
    chk1("gset", 1'b1, 1'b0, 1'b0);
    en = 1'b0; s1 = 1'b0; r1 = 1'b1;
    tick();
    chk1("gclosed0", 1'b1, 1'b0, 1'b0);
    tick();
    chk1("gclosed1", 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    chk1("gopen_rst", 1'b0, 1'b1, 1'b0);

    // reset mid-operation
    s1 = 1'b1; r1 = 1'b0;
    tick();
    chk1("pre_rst", 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk1("mid_rst", 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    en = 1'b0;
    tick();
    chk1("post_rst_hold", 1'b0, 1'b1, 1'b0);
    en = 1'b1; s1 = 1'b0; r1 = 1'b0;
    tick();
    chk1("post_rst_00", 1'b0, 1'b1, 1'b0);

    // mixed per-bit requests; bit0 holds its reset value
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    en = 1'b1; s4 = 4'b1010; r4 = 4'b0110;
    tick();
    chk("mix.q4", q4, 4'b1000);
    chk("mix.qn4", qn4, 4'b0101);
    chk("mix.il4", il4, 4'b0010);
    en = 1'b0; s4 = '0; r4 = '0;

    // randomized run against the model
    pulse_reset();
    model_check("rnd_init");
    rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 3) != 0);
      s1 = 1'($urandom);
      r1 = 1'($urandom);
      s4 = 4'($urandom);
      r4 = 4'($urandom);
      if (!en && $urandom_range(0, 3) == 0) begin
        s4 = 'x;
        r4 = 'z;
        s1 = 'x;
      end
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        m1 = 0;
        for (int i = 0; i < 4; i++) m4[i] = 0;
        #1;
        model_check("rnd_rst");
        rst_n = 1'b1;
      end
      @(posedge clk);
      m1 = next_cell(m1, en, s1, r1);
      for (int i = 0; i < 4; i++)
        m4[i] = next_cell(m4[i], en, s4[i], r4[i]);
      #1;
      model_check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
